register_file_mp: RTL and testbench

Parametrised successor to the single-issue 32x32 register file, for the dual-issue datapath.
- Two write ports and two read ports, with write-to-read bypass; register 0 hardwired to zero.
- Configurable stack-pointer reset entry.
- Hardware clear sequencer that restores reset values one entry per cycle.
- Registered debug read port with a request/valid handshake.

---
 rtl/register_file_mp.sv | 129 ++++++++++++
 tb/tb_register_file_mp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Dual-write, dual-read register file with bypass, hardware clear sequencer
// and an optional registered debug read port (enabled by REGFILE_DEBUG_EN).
//
// state | meaning
// IDLE  | normal operation, writes and bypass active
// CLEAR | entry[idx] restored to its reset value each cycle, writes stalled
// DONE  | one-cycle completion pulse, then back to IDLE
module register_file_mp #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h7fffeffc
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  input  logic                  write_enable_a,
  input  logic [ADDR_WIDTH-1:0] write_address_a,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  input  logic                  write_enable_b,
  input  logic [ADDR_WIDTH-1:0] write_address_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  clear_done,
  input  logic                  debug_req,
  input  logic [ADDR_WIDTH-1:0] read_address_debug,
  output logic [DATA_WIDTH-1:0] data_out_debug,
  output logic                  debug_valid
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  we_a_ok, we_b_ok;

  function automatic logic [DATA_WIDTH-1:0] reset_value(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) == SP_INDEX) ? SP_RESET : '0;
  endfunction

  assign busy       = (state_q == CLEAR);
  assign clear_done = (state_q == DONE);

  // Address-0 writes are dropped here so neither the array nor the bypass sees them.
  assign we_a_ok = write_enable_a && (write_address_a != '0) && !busy;
  assign we_b_ok = write_enable_b && (write_address_b != '0) && !busy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == {ADDR_WIDTH{1'b1}}) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_value(ADDR_WIDTH'(i));
    end else if (busy) begin
      mem_q[idx_q] <= reset_value(idx_q);
    end else begin
      // B is the younger instruction; its assignment is last so it wins.
      if (we_a_ok) mem_q[write_address_a] <= write_data_a;
      if (we_b_ok) mem_q[write_address_b] <= write_data_b;
    end
  end

  assign data_out_1 = (read_address_1 == '0) ? '0 :
                      (we_b_ok && write_address_b == read_address_1) ? write_data_b :
                      (we_a_ok && write_address_a == read_address_1) ? write_data_a :
                      mem_q[read_address_1];

  assign data_out_2 = (read_address_2 == '0) ? '0 :
                      (we_b_ok && write_address_b == read_address_2) ? write_data_b :
                      (we_a_ok && write_address_a == read_address_2) ? write_data_a :
                      mem_q[read_address_2];

`ifdef REGFILE_DEBUG_EN
  logic [DATA_WIDTH-1:0] dbg_data_q;
  logic                  dbg_valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_valid_q <= debug_req;
      if (debug_req) dbg_data_q <= mem_q[read_address_debug];
    end
  end

  assign data_out_debug = dbg_data_q;
  assign debug_valid    = dbg_valid_q;
`else
  logic unused_dbg;
  assign unused_dbg     = ^{debug_req, read_address_debug};
  assign data_out_debug = '0;
  assign debug_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed steps followed by random
// traffic, compared against an array-based reference model.
module tb_register_file_mp;

  localparam logic [31:0] SP = 32'h7fffeffc;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  read_address_1, read_address_2;
  logic [31:0] data_out_1, data_out_2;
  logic        write_enable_a, write_enable_b;
  logic [4:0]  write_address_a, write_address_b;
  logic [31:0] write_data_a, write_data_b;
  logic        clear_start, busy, clear_done;
  logic        debug_req, debug_valid;
  logic [4:0]  read_address_debug;
  logic [31:0] data_out_debug;

  int checks = 0;
  int errors = 0;

  // Reference model state: clr_cnt = -1 idle, 0..31 clearing that entry, 32 done.
  logic [31:0] m_mem [32];
  int          clr_cnt;
  logic        m_dbg_v;
  logic [31:0] m_dbg_d;

  register_file_mp dut (
    .clock(clock), .reset(reset),
    .read_address_1(read_address_1), .read_address_2(read_address_2),
    .data_out_1(data_out_1), .data_out_2(data_out_2),
    .write_enable_a(write_enable_a), .write_address_a(write_address_a), .write_data_a(write_data_a),
    .write_enable_b(write_enable_b), .write_address_b(write_address_b), .write_data_b(write_data_b),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .debug_req(debug_req), .read_address_debug(read_address_debug),
    .data_out_debug(data_out_debug), .debug_valid(debug_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rv(input int i);
    return (i == 29) ? SP : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = rv(i);
    clr_cnt = -1;
    m_dbg_v = 1'b0;
    m_dbg_d = '0;
  endtask

  function automatic logic m_busy();
    return (clr_cnt >= 0) && (clr_cnt < 32);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (!m_busy()) begin
      if (write_enable_b && write_address_b == a) return write_data_b;
      if (write_enable_a && write_address_a == a) return write_data_a;
    end
    return m_mem[a];
  endfunction

  task automatic model_step();
    if (debug_req) begin
      m_dbg_d = m_mem[read_address_debug];
      m_dbg_v = 1'b1;
    end else begin
      m_dbg_v = 1'b0;
    end
    if (m_busy()) begin
      m_mem[clr_cnt] = rv(clr_cnt);
      clr_cnt++;
    end else begin
      if (write_enable_a && write_address_a != 0) m_mem[write_address_a] = write_data_a;
      if (write_enable_b && write_address_b != 0) m_mem[write_address_b] = write_data_b;
      if (clr_cnt == 32) clr_cnt = -1;
      else if (clear_start) clr_cnt = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rd1", data_out_1, m_read(read_address_1));
    chk("rd2", data_out_2, m_read(read_address_2));
    chk("busy", {31'b0, busy}, {31'b0, m_busy()});
    chk("clear_done", {31'b0, clear_done}, {31'b0, clr_cnt == 32});
`ifdef REGFILE_DEBUG_EN
    chk("dbg_valid", {31'b0, debug_valid}, {31'b0, m_dbg_v});
    chk("dbg_data", data_out_debug, m_dbg_d);
`else
    chk("dbg_valid", {31'b0, debug_valid}, 32'h0);
    chk("dbg_data", data_out_debug, 32'h0);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable_a = 0; write_address_a = 0; write_data_a = 0;
    write_enable_b = 0; write_address_b = 0; write_data_b = 0;
    clear_start = 0; debug_req = 0; read_address_debug = 0;
  endtask

  task automatic readback_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_address_1 = 5'(i);
      read_address_2 = 5'(31 - i);
      #1;
      chk(tag, data_out_1, rv(i));
      check_outputs();
      tick();
    end
  endtask

  int busy_cnt, done_cnt;

  initial begin
    idle_inputs();
    read_address_1 = 0; read_address_2 = 0;
    reset = 1'b0;
    model_reset();
    #23;
    check_outputs();
    reset = 1'b1;
    @(posedge clock); #1;
    readback_all("reset_val");

    // dual write with same-cycle bypass
    write_enable_a = 1; write_address_a = 5; write_data_a = 32'h11111111;
    write_enable_b = 1; write_address_b = 6; write_data_b = 32'h22222222;
    read_address_1 = 5; read_address_2 = 6; #1;
    chk("byp_r5", data_out_1, 32'h11111111);
    chk("byp_r6", data_out_2, 32'h22222222);
    tick(); idle_inputs(); #1;
    chk("st_r5", data_out_1, 32'h11111111);
    chk("st_r6", data_out_2, 32'h22222222);

    // both ports to r7: B wins
    write_enable_a = 1; write_address_a = 7; write_data_a = 32'hAAAA0000;
    write_enable_b = 1; write_address_b = 7; write_data_b = 32'hBBBB0000;
    read_address_1 = 7; #1;
    chk("byp_r7", data_out_1, 32'hBBBB0000);
    tick(); idle_inputs(); #1;
    chk("st_r7", data_out_1, 32'hBBBB0000);

    // zero register
    write_enable_a = 1; write_address_a = 0; write_data_a = 32'hFFFFFFFF;
    write_enable_b = 1; write_address_b = 0; write_data_b = 32'hFFFFFFFF;
    read_address_1 = 0; read_address_2 = 0; #1;
    chk("byp_r0_1", data_out_1, 32'h0);
    chk("byp_r0_2", data_out_2, 32'h0);
    tick(); idle_inputs(); #1;
    chk("st_r0", data_out_1, 32'h0);

    // fill with DEADBEEF then clear
    for (int i = 0; i < 16; i++) begin
      write_enable_a = 1; write_address_a = 5'(2*i);   write_data_a = 32'hDEADBEEF;
      write_enable_b = 1; write_address_b = 5'(2*i+1); write_data_b = 32'hDEADBEEF;
      tick();
    end
    idle_inputs();
    clear_start = 1; #1;
    check_outputs();
    tick();
    clear_start = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 5) begin
        write_enable_a = 1; write_address_a = 2; write_data_a = 32'h55555555;
        read_address_1 = 2;
      end
      #1;
      check_outputs();
      if (busy) busy_cnt++;
      if (clear_done) done_cnt++;
      tick();
      idle_inputs();
    end
    chk("busy_cycles", busy_cnt, 32);
    chk("done_pulses", done_cnt, 1);
    readback_all("after_clear");

    // reset in the middle of a clear
    write_enable_a = 1; write_address_a = 4; write_data_a = 32'hDEADBEEF;
    write_enable_b = 1; write_address_b = 8; write_data_b = 32'hDEADBEEF;
    tick(); idle_inputs();
    clear_start = 1; #1; tick(); clear_start = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1; check_outputs(); tick();
    end
    reset = 1'b0; #1;
    model_reset();
    chk("midclr_busy", {31'b0, busy}, 32'h0);
    chk("midclr_done", {31'b0, clear_done}, 32'h0);
    #2; reset = 1'b1;
    @(posedge clock); #1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1; check_outputs();
      if (clear_done) done_cnt++;
      tick();
    end
    chk("midclr_no_done", done_cnt, 0);
    readback_all("after_midclr");

    // debug read
    write_enable_a = 1; write_address_a = 3; write_data_a = 32'h12345678;
    tick(); idle_inputs();
    debug_req = 1; read_address_debug = 3; #1;
    check_outputs();
    tick();
    debug_req = 0; #1;
`ifdef REGFILE_DEBUG_EN
    chk("dbg_r3_valid", {31'b0, debug_valid}, 32'h1);
    chk("dbg_r3_data", data_out_debug, 32'h12345678);
`else
    chk("dbg_r3_valid", {31'b0, debug_valid}, 32'h0);
    chk("dbg_r3_data", data_out_debug, 32'h0);
`endif
    check_outputs();
    tick(); #1;
    chk("dbg_drop", {31'b0, debug_valid}, 32'h0);
    check_outputs();

    // random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      write_enable_a     = 1'($urandom_range(0, 1));
      write_address_a    = 5'($urandom_range(0, 31));
      write_data_a       = $urandom;
      write_enable_b     = 1'($urandom_range(0, 1));
      write_address_b    = ($urandom_range(0, 3) == 0) ? write_address_a : 5'($urandom_range(0, 31));
      write_data_b       = $urandom;
      read_address_1     = ($urandom_range(0, 2) == 0) ? write_address_a : 5'($urandom_range(0, 31));
      read_address_2     = ($urandom_range(0, 2) == 0) ? write_address_b : 5'($urandom_range(0, 31));
      clear_start        = ($urandom_range(0, 59) == 0);
      debug_req          = 1'($urandom_range(0, 1));
      read_address_debug = ($urandom_range(0, 2) == 0) ? write_address_a : 5'($urandom_range(0, 31));
      #1;
      check_outputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
